// File: rtl/matriz_pkg.sv
// Shared types and helpers for the LED-matrix column scanner.
package matriz_pkg;

    typedef enum logic [1:0] {StIdle, StBlank, StDrive} state_e;

    // Widest column count the one-hot helper supports.
    localparam int unsigned MaxCols = 64;

    function automatic logic [MaxCols-1:0] col_onehot(input int unsigned idx);
        return {{(MaxCols-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/matriz_frame_buf.sv
// Double-buffered frame store: a producer fills pending, the scanner swaps it in at frame wrap.
module matriz_frame_buf #(
    parameter int unsigned W = 35
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [W-1:0] data_in,
    input  logic         valid,
    output logic         ready,
    input  logic         swap,
    output logic [W-1:0] active_out
);

    logic [W-1:0] pending_q, pending_d;
    logic [W-1:0] active_q, active_d;
    logic         pending_full_q, pending_full_d;
    logic         accept;
    logic         do_swap;

    assign ready   = !pending_full_q;
    assign accept  = valid && ready;
    assign do_swap = swap && pending_full_q;

    // The image in effect after the coming edge, so registered row outputs see a swap
    // on the same edge that starts column 0.
    assign active_out = do_swap ? pending_q : active_q;

    always_comb begin
        pending_d      = pending_q;
        active_d       = active_q;
        pending_full_d = pending_full_q;
        if (do_swap) begin
            active_d       = pending_q;
            pending_full_d = 1'b0;
        end
        // Accept only happens with pending empty, so it never collides with a real swap.
        if (accept) begin
            pending_d      = data_in;
            pending_full_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_q      <= '0;
            active_q       <= '0;
            pending_full_q <= 1'b0;
        end else begin
            pending_q      <= pending_d;
            active_q       <= active_d;
            pending_full_q <= pending_full_d;
        end
    end

endmodule

// File: rtl/matriz_scan_ctrl.sv
// LED-matrix column scanner: one-hot column drive with blanking gap, per-column PWM rows
// and tear-free double-buffered frames.
module matriz_scan_ctrl
    import matriz_pkg::*;
#(
    parameter int unsigned NUM_COLS        = 5,
    parameter int unsigned NUM_ROWS        = 7,
    parameter int unsigned DWELL_CYC       = 8,
    parameter int unsigned BLANK_CYC       = 2,
    parameter int unsigned BR_W            = 4,
    parameter bit          COL_ACTIVE_HIGH = 1'b1,
    parameter bit          ROW_ACTIVE_HIGH = 1'b1
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic [NUM_COLS*NUM_ROWS-1:0] frame_data,
    input  logic                         frame_valid,
    output logic                         frame_ready,
    input  logic [BR_W-1:0]              brightness,
    output logic [NUM_COLS-1:0]          colunas,
    output logic [NUM_ROWS-1:0]          linhas,
    output logic                         frame_start
);

    localparam int unsigned FrameW = NUM_COLS * NUM_ROWS;
    localparam int unsigned ColW   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int unsigned DwW    = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
    localparam int unsigned BlW    = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam int unsigned CmpW   = (BR_W > DwW) ? BR_W : DwW;
    localparam int unsigned IdxW   = (FrameW > 1) ? $clog2(FrameW) : 1;

    localparam logic [NUM_COLS-1:0] ColInv  = {NUM_COLS{~COL_ACTIVE_HIGH}};
    localparam logic [NUM_ROWS-1:0] RowInv  = {NUM_ROWS{~ROW_ACTIVE_HIGH}};
    localparam state_e              FirstSt = (BLANK_CYC > 0) ? StBlank : StDrive;

    state_e              state_q, state_d;
    logic [ColW-1:0]     col_q, col_d;
    logic [DwW-1:0]      dwell_q, dwell_d;
    logic [BlW-1:0]      blank_q, blank_d;
    logic [BR_W-1:0]     br_q, br_d;
    logic [NUM_COLS-1:0] colunas_q, colunas_d;
    logic [NUM_ROWS-1:0] linhas_q, linhas_d;
    logic                frame_start_q, frame_start_d;

    logic                swap;
    logic                enter_col;
    logic [FrameW-1:0]   active_img;
    logic [IdxW-1:0]     row_base;
    logic [NUM_COLS-1:0] col_act;
    logic [NUM_ROWS-1:0] row_act;

    matriz_frame_buf #(
        .W(FrameW)
    ) u_frame_buf (
        .clock     (clock),
        .reset_n   (reset_n),
        .data_in   (frame_data),
        .valid     (frame_valid),
        .ready     (frame_ready),
        .swap      (swap),
        .active_out(active_img)
    );

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        dwell_d       = dwell_q;
        blank_d       = blank_q;
        br_d          = br_q;
        frame_start_d = 1'b0;
        swap          = 1'b0;
        enter_col     = 1'b0;

        if (!enable) begin
            state_d = StIdle;
            col_d   = '0;
            dwell_d = '0;
            blank_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    col_d         = '0;
                    frame_start_d = 1'b1;
                    enter_col     = 1'b1;
                end
                StBlank: begin
                    if (blank_q == BlW'(BLANK_CYC - 1)) begin
                        state_d = StDrive;
                        blank_d = '0;
                        dwell_d = '0;
                    end else begin
                        blank_d = blank_q + BlW'(1);
                    end
                end
                StDrive: begin
                    if (dwell_q == DwW'(DWELL_CYC - 1)) begin
                        enter_col = 1'b1;
                        if (col_q == ColW'(NUM_COLS - 1)) begin
                            col_d         = '0;
                            swap          = 1'b1;
                            frame_start_d = 1'b1;
                        end else begin
                            col_d = col_q + ColW'(1);
                        end
                    end else begin
                        dwell_d = dwell_q + DwW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // Brightness is sampled once per column so mid-column changes cannot tear the PWM.
        if (enter_col) begin
            state_d = FirstSt;
            blank_d = '0;
            dwell_d = '0;
            br_d    = brightness;
        end

        row_base = IdxW'(32'(col_d) * NUM_ROWS);
        col_act  = '0;
        row_act  = '0;
        if (state_d == StDrive) begin
            col_act = NUM_COLS'(col_onehot(32'(col_d)));
            if (CmpW'(dwell_d) < CmpW'(br_d)) begin
                row_act = active_img[row_base +: NUM_ROWS];
            end
        end
        colunas_d = col_act ^ ColInv;
        linhas_d  = row_act ^ RowInv;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            col_q         <= '0;
            dwell_q       <= '0;
            blank_q       <= '0;
            br_q          <= '0;
            colunas_q     <= ColInv;
            linhas_q      <= RowInv;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            dwell_q       <= dwell_d;
            blank_q       <= blank_d;
            br_q          <= br_d;
            colunas_q     <= colunas_d;
            linhas_q      <= linhas_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign colunas     = colunas_q;
    assign linhas      = linhas_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_matriz_scan_ctrl.sv
// Directed bench for matriz_scan_ctrl: default 5x7 instance plus an 8-column active-low,
// no-blanking instance.
module tb_matriz_scan_ctrl;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n, enable, frame_valid, frame_ready, frame_start;
    logic [34:0] frame_data;
    logic [3:0]  brightness;
    logic [4:0]  colunas;
    logic [6:0]  linhas;

    logic        reset2_n, enable2, valid2, ready2, start2;
    logic [55:0] data2;
    logic [3:0]  br2;
    logic [7:0]  col2;
    logic [6:0]  lin2;

    int n_total = 0;
    int n_bad   = 0;
    int fr      = 0;

    matriz_scan_ctrl dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .frame_data (frame_data),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .brightness (brightness),
        .colunas    (colunas),
        .linhas     (linhas),
        .frame_start(frame_start)
    );

    matriz_scan_ctrl #(
        .NUM_COLS       (8),
        .BLANK_CYC      (0),
        .COL_ACTIVE_HIGH(1'b0),
        .ROW_ACTIVE_HIGH(1'b0)
    ) dut2 (
        .clock      (clock),
        .reset_n    (reset2_n),
        .enable     (enable2),
        .frame_data (data2),
        .frame_valid(valid2),
        .frame_ready(ready2),
        .brightness (br2),
        .colunas    (col2),
        .linhas     (lin2),
        .frame_start(start2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Column patterns: 0 blank, 1 diagonal, 2 frame B, 3 frame C, 4 frame D.
    function automatic logic [6:0] pat(input int kind, input int c);
        case (kind)
            1:       return 7'(1 << c);
            2:       return 7'(7'h40 >> c) | 7'h01;
            3:       return 7'h7F;
            4:       return 7'(7'h2A ^ c);
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [34:0] mkf(input int kind);
        logic [34:0] f;
        f = '0;
        for (int c = 0; c < 5; c++) f[c*7 +: 7] = pat(kind, c);
        return f;
    endfunction

    // k is the cycle within a 50-cycle frame: 2 blank then 8 drive per column.
    task automatic cmp_cycle(input int k, input int kind, input int br);
        int c, p;
        logic [4:0] ec;
        logic [6:0] el;
        c  = k / 10;
        p  = k % 10;
        ec = (p >= 2) ? 5'(1 << c) : 5'h0;
        el = (p >= 2 && (p - 2) < br) ? pat(kind, c) : 7'h0;
        check($sformatf("f%0d k%0d col", fr, k), 32'(colunas), 32'(ec));
        check($sformatf("f%0d k%0d lin", fr, k), 32'(linhas), 32'(el));
        check($sformatf("f%0d k%0d fs", fr, k), 32'(frame_start), (k == 0) ? 32'd1 : 32'd0);
    endtask

    task automatic run_frame(input int kind, input int br, input int nbr);
        for (int k = 0; k < 50; k++) begin
            cmp_cycle(k, kind, br);
            if (k == 49) brightness = 4'(nbr);
            tick();
        end
        fr++;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " col"}, 32'(colunas), 32'h0);
        check({tag, " lin"}, 32'(linhas), 32'h0);
        check({tag, " fs"}, 32'(frame_start), 32'h0);
    endtask

    initial begin
        reset_n     = 1'b0;
        enable      = 1'b0;
        frame_valid = 1'b0;
        frame_data  = '0;
        brightness  = 4'd15;
        reset2_n    = 1'b0;
        enable2     = 1'b0;
        valid2      = 1'b0;
        data2       = '0;
        br2         = 4'd5;
        repeat (3) @(posedge clock);
        #1;
        check_idle("rst");
        check("rst ready", 32'(frame_ready), 32'd1);
        check("rst2 col", 32'(col2), 32'hFF);
        check("rst2 lin", 32'(lin2), 32'h7F);
        check("rst2 fs", 32'(start2), 32'd0);

        // Load the diagonal while idle; it only shows after the first wrap.
        reset_n     = 1'b1;
        frame_data  = mkf(1);
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        check("idle accept ready", 32'(frame_ready), 32'd0);
        enable = 1'b1;
        tick();
        run_frame(0, 15, 15);
        check("wrap ready", 32'(frame_ready), 32'd1);
        run_frame(1, 15, 3);
        run_frame(1, 3, 0);
        run_frame(1, 0, 15);

        // Offer B mid-frame, then C while B is pending.
        for (int k = 0; k < 50; k++) begin
            cmp_cycle(k, 1, 15);
            if (k == 10) begin
                frame_data  = mkf(2);
                frame_valid = 1'b1;
            end
            if (k == 11) begin
                check("ready after B", 32'(frame_ready), 32'd0);
                frame_data = mkf(3);
            end
            if (k == 30) begin
                check("ready held", 32'(frame_ready), 32'd0);
                frame_valid = 1'b0;
            end
            tick();
        end
        fr++;
        check("ready after swap", 32'(frame_ready), 32'd1);
        run_frame(2, 15, 15);
        run_frame(2, 15, 15);

        // Accept D on the exact wrap edge: B stays for one more frame.
        for (int k = 0; k < 50; k++) begin
            cmp_cycle(k, 2, 15);
            if (k == 49) begin
                frame_data  = mkf(4);
                frame_valid = 1'b1;
            end
            tick();
        end
        fr++;
        frame_valid = 1'b0;
        check("ready wrap accept", 32'(frame_ready), 32'd0);
        run_frame(2, 15, 15);

        // Mid-column brightness change only applies from the next column.
        for (int k = 0; k < 50; k++) begin
            cmp_cycle(k, 4, (k / 10 <= 1) ? 15 : 2);
            if (k == 13) brightness = 4'd2;
            if (k == 49) brightness = 4'd15;
            tick();
        end
        fr++;

        // Disable during column 3 drive.
        for (int k = 0; k <= 35; k++) begin
            cmp_cycle(k, 4, 15);
            if (k < 35) tick();
        end
        enable = 1'b0;
        tick();
        check_idle("dis");
        tick();
        tick();
        check_idle("dis hold");
        enable = 1'b1;
        tick();
        fr++;
        run_frame(4, 15, 15);

        // Asynchronous reset mid-frame clears outputs at once and the active image.
        for (int k = 0; k <= 25; k++) begin
            cmp_cycle(k, 4, 15);
            if (k < 25) tick();
        end
        #2 reset_n = 1'b0;
        #1;
        check_idle("async rst");
        check("async rst ready", 32'(frame_ready), 32'd1);
        #3 reset_n = 1'b1;
        tick();
        fr++;
        run_frame(0, 15, 15);

        // Active-low 8-column instance, no blanking: 64-cycle frame.
        reset2_n = 1'b1;
        for (int c = 0; c < 8; c++) data2[c*7 +: 7] = 7'(c + 1);
        valid2 = 1'b1;
        tick();
        valid2  = 1'b0;
        enable2 = 1'b1;
        tick();
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 64; k++) begin
                logic [7:0] ec;
                logic [6:0] el;
                ec = ~8'(1 << (k / 8));
                el = ((k % 8) < 5 && f == 1) ? 7'((k / 8) + 1) : 7'h0;
                el = ~el;
                check($sformatf("d2 f%0d k%0d col", f, k), 32'(col2), 32'(ec));
                check($sformatf("d2 f%0d k%0d lin", f, k), 32'(lin2), 32'(el));
                check($sformatf("d2 f%0d k%0d fs", f, k), 32'(start2),
                      (k == 0) ? 32'd1 : 32'd0);
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/matriz_scan_ctrl.md
Name: matriz_scan_ctrl

Overview:
Parametrised LED-matrix column scanner and successor to the fixed 5x7 scanner. It drives one column at a time, one-hot, with a programmable dwell time and an inter-column blanking gap for anti-ghosting. Per-column PWM brightness is supported. Frames are loaded through a double-buffered valid/ready interface, so a new image only takes effect at a frame boundary (tear-free). It sits between the character/pattern generator and the matrix pins.

Parameters:
NUM_COLS, 5, number of columns scanned (>=1)
NUM_ROWS, 7, number of row lines per column (>=1)
DWELL_CYC, 8, clock cycles each column is in DRIVE (>=1)
BLANK_CYC, 2, clock cycles all outputs are inactive before each column (>=0; 0 = no blanking)
BR_W, 4, brightness word width
COL_ACTIVE_HIGH, 1, 1 = a driven column is 1 on colunas; 0 = active-low
ROW_ACTIVE_HIGH, 1, 1 = a lit row is 1 on linhas; 0 = active-low

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
enable  in  1  scanning enabled
frame_data  in  NUM_COLS*NUM_ROWS  image; column c = frame_data[c*NUM_ROWS +: NUM_ROWS], bit r = row r, 1 = lit
frame_valid  in  1  frame_data is offered
frame_ready  out  1  pending buffer empty; a frame is accepted when valid && ready
brightness  in  BR_W  on-time in cycles within DWELL (values >= DWELL_CYC = full on; 0 = dark)
colunas  out  NUM_COLS  column drive, one-hot when active (polarity per COL_ACTIVE_HIGH)
linhas  out  NUM_ROWS  row drive (polarity per ROW_ACTIVE_HIGH)
frame_start  out  1  one-cycle pulse on the first cycle of column 0 of each frame

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, col_idx=0, dwell/blank counters=0.
  - Active buffer all 0; pending buffer empty, so frame_ready=1.
  - colunas and linhas at their inactive levels; frame_start=0.
- All outputs are registered except frame_ready, which is combinational as !pending_full.
- States:
  - IDLE: outputs inactive.
  - BLANK: all columns and rows inactive. Lasts BLANK_CYC cycles; skipped entirely when BLANK_CYC=0.
  - DRIVE: colunas has only bit col_idx active for DWELL_CYC cycles.
    - linhas = column col_idx of the active buffer while dwell_cnt < br_lat, otherwise inactive.
    - br_lat is brightness latched on the first cycle of each column's BLANK (or DRIVE when BLANK_CYC=0). Changes to brightness mid-column have no effect.
- Transitions:
  - IDLE & enable -> BLANK (or DRIVE), col_idx=0, frame_start=1 for that first cycle.
  - End of DRIVE with col_idx < NUM_COLS-1 -> col_idx+1, next BLANK.
  - End of DRIVE with col_idx = NUM_COLS-1 -> wrap: col_idx=0, frame swap, frame_start pulse on the first cycle of the new column 0.
  - enable=0 in any state -> IDLE on the next edge, outputs inactive, col_idx=0. Re-enabling restarts at column 0 with a frame_start pulse.
- Frame period = NUM_COLS*(BLANK_CYC+DWELL_CYC) cycles. Defaults give 5*10 = 50.
- Double buffer:
  - Accept (frame_valid & frame_ready) writes pending and sets pending_full.
  - Swap happens at the frame wrap edge: if pending_full, active <= pending and pending_full clears; else active is unchanged.
  - Accept and swap on the same edge: the accepted data goes to pending and is not displayed until the next wrap; active is unchanged.
  - Offers while pending_full are ignored (ready=0). The producer holds frame_data stable until accepted.
  - A frame accepted in IDLE swaps at the first wrap after enable.
- Polarity: internal logic is active-high. Outputs are XOR-inverted according to the *_ACTIVE_HIGH parameters, including the inactive/reset levels.
- Counters are sized with $clog2 of their maximum (minimum width 1). The brightness compare is done at max(BR_W, dwell counter width), zero-extended.

Decomposition:
- Package matriz_pkg: state enum (IDLE, BLANK, DRIVE) and a function returning a one-hot column vector for an index.
- Sub-module matriz_frame_buf: pending/active registers, pending_full flag, accept and swap logic. Ports: clock, reset_n, data_in, valid, ready, swap, active_out.
- Top level holds the FSM, counters, PWM compare and output polarity.

Test Plan:
- Reset, then enable=1, brightness=15, one frame loaded as column c = 7'(1<<c) -> colunas 00001, 00010, 00100, 01000, 10000 each for 8 cycles; a 2-cycle all-zero gap precedes each column; linhas = 0000001, 0000010, ... ; frame_start pulse every 50 cycles.
- brightness=3 -> in each DRIVE, linhas shows column data for 3 cycles then 0 for 5; brightness=0 -> linhas stays 0; a brightness change mid-column takes effect from the next column.
- Frame A displaying, offer frame B mid-frame -> frame_ready falls to 0 after accept; B first appears at column 0 after the next wrap; frame_ready returns to 1 on the wrap edge; offer C while B is pending -> ignored.
- Accept on the exact wrap edge with pending empty -> active unchanged for that frame; new data shown one frame later.
- enable=0 during column 3 DRIVE -> next cycle all outputs inactive; re-enable -> frame_start pulse, column 0 first. reset_n pulse mid-frame -> outputs inactive immediately (asynchronously), active buffer cleared.
- COL_ACTIVE_HIGH=0, ROW_ACTIVE_HIGH=0, BLANK_CYC=0, NUM_COLS=8 -> inactive colunas = 8'hFF, active column = 0 bit; no blanking gap; frame period 64.
